// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown scheduler: FSM state type and encodings.
package countdown_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t LOAD  = 2'd1;
    localparam state_t COUNT = 2'd2;
    localparam state_t DONE  = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from last_idx+1 upward (wrapping)
// and returns the first active requester as one-hot plus its index.
module rr_arbiter
    import countdown_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_idx) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found            = 1'b1;
                gnt_onehot[cand] = 1'b1;
                gnt_idx          = cand;
            end
        end
    end

endmodule

// File: rtl/countdown_scheduler.sv
// Round-robin countdown scheduler: grants one requester, counts its load value
// down to zero, pulses done. Define COUNTDOWN_SCHEDULER_ABORT_EN to add an abort input.
module countdown_scheduler
    import countdown_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] load_val,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         count
`ifdef COUNTDOWN_SCHEDULER_ABORT_EN
    ,
    input  logic                     abort
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic [IDX_W-1:0]     last_idx_q, last_idx_d;

    logic [NUM_REQ-1:0]   arb_onehot;
    logic [IDX_W-1:0]     arb_idx;
    logic [WIDTH-1:0]     slices [NUM_REQ];
    logic [WIDTH-1:0]     sel_val;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req),
        .last_idx   (last_idx_q),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx)
    );

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign slices[i] = load_val[i*WIDTH +: WIDTH];
    end

    // last_idx_q holds the granted index for the whole transaction
    assign sel_val = slices[last_idx_q];

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        count_d    = count_q;
        last_idx_d = last_idx_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (|req) begin
                    gnt_d      = arb_onehot;
                    last_idx_d = arb_idx;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                count_d = sel_val;
                state_d = (sel_val != '0) ? COUNT : DONE;
            end
            COUNT: begin
                count_d = count_q - WIDTH'(1);
                if (count_q == WIDTH'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
`ifdef COUNTDOWN_SCHEDULER_ABORT_EN
        // Abort drops the grant but leaves count frozen where it stopped
        if (abort && (state_q == LOAD || state_q == COUNT)) begin
            state_d = IDLE;
            gnt_d   = '0;
            count_d = count_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            count_q    <= '0;
            last_idx_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            count_q    <= count_d;
            last_idx_q <= last_idx_d;
        end
    end

    assign gnt   = gnt_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign count = count_q;

endmodule

// File: tb/tb_countdown_scheduler.sv
// Self-checking bench for countdown_scheduler: directed scenarios plus random
// traffic against a transaction-level schedule model.
module tb_countdown_scheduler;

    localparam int NR = 4;
    localparam int W  = 8;
`ifdef COUNTDOWN_SCHEDULER_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [NR*W-1:0] load_val = '0;
    logic            abort = 1'b0;
    logic [NR-1:0]   gnt;
    logic            busy;
    logic            done;
    logic [W-1:0]    count;

    int compared = 0;
    int mismatched = 0;

    countdown_scheduler #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .load_val (load_val),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done),
        .count    (count)
`ifdef COUNTDOWN_SCHEDULER_ABORT_EN
        ,
        .abort    (abort)
`endif
    );

    always #5 clk = ~clk;

    // Expected outputs for one cycle
    typedef struct packed {
        logic [NR-1:0] gnt;
        logic          busy;
        logic          done;
        logic [W-1:0]  count;
    } exp_t;

    exp_t sched[$];
    exp_t cur;
    bit   await_load;
    int   m_gidx;
    int   m_last;
    logic [W-1:0] m_count;

    function automatic exp_t mk(logic [NR-1:0] g, logic b, logic d, logic [W-1:0] c);
        exp_t e;
        e.gnt = g; e.busy = b; e.done = d; e.count = c;
        return e;
    endfunction

    function automatic int pick(logic [NR-1:0] r, int last);
        for (int k = 1; k <= NR; k++) begin
            if (r[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic modelReset();
        sched.delete();
        await_load = 1'b0;
        m_last     = NR - 1;
        m_gidx     = 0;
        m_count    = '0;
        cur        = mk('0, 1'b0, 1'b0, '0);
    endtask

    // Advance the model by one clock edge using the inputs presented before it
    task automatic modelStep();
        exp_t e;
        logic [NR*W-1:0] lv;
        int v;
        lv = load_val;
        if (ABORT_EN && abort && cur.busy && !cur.done) begin
            sched.delete();
            await_load = 1'b0;
            m_count    = cur.count;
            e = mk('0, 1'b0, 1'b0, m_count);
        end else begin
            if (await_load) begin
                logic [NR-1:0] oh;
                oh = NR'(1) << m_gidx;
                v  = int'(lv[m_gidx*W +: W]);
                await_load = 1'b0;
                for (int k = v; k >= 1; k--) sched.push_back(mk(oh, 1'b1, 1'b0, W'(k)));
                sched.push_back(mk(oh, 1'b1, 1'b1, '0));
                sched.push_back(mk('0, 1'b0, 1'b0, '0));
                m_count = '0;
            end
            if (sched.size() > 0) begin
                e = sched.pop_front();
            end else if (req != '0) begin
                m_gidx     = pick(req, m_last);
                m_last     = m_gidx;
                await_load = 1'b1;
                e = mk(NR'(1) << m_gidx, 1'b1, 1'b0, m_count);
            end else begin
                e = mk('0, 1'b0, 1'b0, m_count);
            end
        end
        cur = e;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NR-1:0] r, input logic [NR*W-1:0] lv, input logic ab);
        @(negedge clk);
        req      = r;
        load_val = lv;
        abort    = ab;
        @(posedge clk);
        #1;
        modelStep();
        checkOutput("gnt",   32'(gnt),   32'(cur.gnt));
        checkOutput("busy",  32'(busy),  32'(cur.busy));
        checkOutput("done",  32'(done),  32'(cur.done));
        checkOutput("count", 32'(count), 32'(cur.count));
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        abort = 1'b0;
        #1;
        checkOutput({tag, "_gnt"},   32'(gnt),   32'd0);
        checkOutput({tag, "_busy"},  32'(busy),  32'd0);
        checkOutput({tag, "_done"},  32'(done),  32'd0);
        checkOutput({tag, "_count"}, 32'(count), 32'd0);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [NR*W-1:0] lv;
        logic [NR-1:0]   r;
        logic [NR-1:0]   grants [5];
        int n, ng, seen_done;

        modelReset();
        repeat (2) @(negedge clk);
        doReset("reset");

        // Single requester, load 3
        lv = '0; lv[0*W +: W] = 8'd3;
        applyStimulus(4'b0001, lv, 1'b0);
        checkOutput("first_gnt", 32'(gnt), 32'h1);
        n = 1;
        while (busy && n < 20) begin
            applyStimulus(4'b0000, lv, 1'b0);
            if (busy) n++;
        end
        checkOutput("busy_cycles", 32'(n), 32'd5);

        // All requesting, all loads 1: rotation from reset
        doReset("reset2");
        lv = {8'd1, 8'd1, 8'd1, 8'd1};
        ng = 0; n = 0; seen_done = 0;
        while (ng < 5 && n < 60) begin
            applyStimulus(4'b1111, lv, 1'b0);
            if (cur.busy && sched.size() == 0 && await_load) begin
                grants[ng] = gnt;
                ng++;
            end
            if (done) seen_done++;
            n++;
        end
        checkOutput("rr_ngrants", 32'(ng), 32'd5);
        checkOutput("rr_g0", 32'(grants[0]), 32'h1);
        checkOutput("rr_g1", 32'(grants[1]), 32'h2);
        checkOutput("rr_g2", 32'(grants[2]), 32'h4);
        checkOutput("rr_g3", 32'(grants[3]), 32'h8);
        checkOutput("rr_g4", 32'(grants[4]), 32'h1);
        checkOutput("rr_dones", 32'(seen_done), 32'd4);
        repeat (4) applyStimulus(4'b0000, lv, 1'b0);

        // Zero load on requester 2: LOAD then DONE directly
        lv = '0;
        applyStimulus(4'b0100, lv, 1'b0);
        applyStimulus(4'b0000, lv, 1'b0);
        checkOutput("zero_done", 32'(done), 32'd1);
        checkOutput("zero_count", 32'(count), 32'd0);
        applyStimulus(4'b0000, lv, 1'b0);

        // Reset in the middle of a countdown
        lv = '0; lv[1*W +: W] = 8'd9;
        applyStimulus(4'b0010, lv, 1'b0);
        n = 0;
        while (!(cur.busy && !cur.done && !await_load && cur.count == 8'd5) && n < 20) begin
            applyStimulus(4'b0000, lv, 1'b0);
            n++;
        end
        checkOutput("reach_count5", 32'(count), 32'd5);
        doReset("midreset");
        applyStimulus(4'b1111, lv, 1'b0);
        checkOutput("post_reset_gnt", 32'(gnt), 32'h1);
        repeat (4) applyStimulus(4'b0000, lv, 1'b0);

        // Requester 1 drops its request mid-countdown
        lv = '0; lv[1*W +: W] = 8'd4;
        applyStimulus(4'b0010, lv, 1'b0);
        applyStimulus(4'b0010, lv, 1'b0);
        applyStimulus(4'b0000, lv, 1'b0);
        checkOutput("drop_held", 32'(gnt), 32'h2);
        seen_done = 0;
        repeat (8) begin
            applyStimulus(4'b0000, lv, 1'b0);
            if (done) seen_done++;
        end
        checkOutput("drop_done", 32'(seen_done), 32'd1);
        checkOutput("drop_no_regrant", 32'(gnt), 32'd0);

        // Full-scale countdown
        lv = '0; lv[3*W +: W] = 8'hFF;
        applyStimulus(4'b1000, lv, 1'b0);
        n = 0;
        while (!done && n < 300) begin
            applyStimulus(4'b0000, lv, 1'b0);
            n++;
        end
        checkOutput("full_scale_cycles", 32'(n), 32'd256);
        applyStimulus(4'b0000, lv, 1'b0);

`ifdef COUNTDOWN_SCHEDULER_ABORT_EN
        lv = '0; lv[0*W +: W] = 8'd10;
        applyStimulus(4'b0001, lv, 1'b0);
        n = 0;
        while (count != 8'd7 && n < 20) begin
            applyStimulus(4'b0000, lv, 1'b0);
            n++;
        end
        applyStimulus(4'b0000, lv, 1'b1);
        checkOutput("abort_gnt", 32'(gnt), 32'd0);
        checkOutput("abort_count", 32'(count), 32'd7);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        applyStimulus(4'b0000, lv, 1'b0);
`endif

        // Random traffic
        for (int it = 0; it < 500; it++) begin
            r = ($urandom_range(0, 9) < 3) ? 4'b0000 : NR'($urandom_range(0, 15));
            for (int s = 0; s < NR; s++) begin
                lv[s*W +: W] = ($urandom_range(0, 29) == 0) ? 8'hFF : W'($urandom_range(0, 5));
            end
            applyStimulus(r, lv, ABORT_EN && ($urandom_range(0, 19) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
